// File: rtl/lfsr_draw_gen.sv
// lfsr_draw_gen: Fibonacci LFSR random-number source with seed loading,
// free-running mode and a req/valid/ready draw interface. Each draw advances
// the register OUT_W steps and returns the OUT_W new feedback bits, MSB first.
// Optional macro LFSR_ZERO_GUARD_EN: replace an all-zero register with SEED
// and keep zero_lock set until reset; without it zero_lock mirrors state == 0.

module lfsr_draw_gen #(
  parameter int              WIDTH = 16,
  parameter logic [WIDTH-1:0] TAPS  = 16'hB400,
  parameter logic [WIDTH-1:0] SEED  = 16'h5555,
  parameter int              OUT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             seed_load,
  input  logic [WIDTH-1:0] seed_in,
  input  logic             free_run,
  input  logic             req,
  output logic             busy,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic [WIDTH-1:0] state_out,
  output logic             zero_lock
);

  localparam int CNT_W = $clog2(OUT_W + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(OUT_W - 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_VALID = 2'd2;

  logic [1:0]       fsm_q, fsm_nxt;
  logic [CNT_W-1:0] cnt_q, cnt_nxt;
  logic [WIDTH-1:0] lfsr_q, lfsr_nxt;
  logic [OUT_W-1:0] data_q, data_nxt;
  logic             zlock_q, zlock_nxt;

  logic             fb;
  logic [WIDTH-1:0] stepped;
  logic [OUT_W-1:0] shifted;

  assign fb      = ^(lfsr_q & TAPS);
  assign stepped = {lfsr_q[WIDTH-2:0], fb};

  // A one-bit draw word is just the new feedback bit; wider words shift it in at the LSB.
  generate
    if (OUT_W == 1) begin : g_one_bit
      assign shifted = fb;
    end else begin : g_multi_bit
      assign shifted = {data_q[OUT_W-2:0], fb};
    end
  endgenerate

  // Next-state selection: seed_load dominates, then zero recovery (if enabled), then the draw FSM.
  always_comb begin
    fsm_nxt   = fsm_q;
    cnt_nxt   = cnt_q;
    lfsr_nxt  = lfsr_q;
    data_nxt  = data_q;
    zlock_nxt = zlock_q;

    if (seed_load) begin
      fsm_nxt = ST_IDLE;
      cnt_nxt = '0;
`ifdef LFSR_ZERO_GUARD_EN
      if (seed_in == '0) begin
        lfsr_nxt  = SEED;
        zlock_nxt = 1'b1;
      end else begin
        lfsr_nxt = seed_in;
      end
`else
      lfsr_nxt = seed_in;
`endif
    end
`ifdef LFSR_ZERO_GUARD_EN
    else if (lfsr_q == '0) begin
      lfsr_nxt  = SEED;
      zlock_nxt = 1'b1;
    end
`endif
    else begin
      case (fsm_q)
        ST_IDLE: begin
          if (req) begin
            fsm_nxt = ST_SHIFT;
            cnt_nxt = '0;
          end else if (free_run) begin
            lfsr_nxt = stepped;
          end
        end
        ST_SHIFT: begin
          lfsr_nxt = stepped;
          data_nxt = shifted;
          cnt_nxt  = cnt_q + CNT_W'(1);
          if (cnt_q == LAST_CNT) begin
            fsm_nxt = ST_VALID;
          end
        end
        ST_VALID: begin
          if (out_ready) begin
            if (req) begin
              fsm_nxt = ST_SHIFT;
              cnt_nxt = '0;
            end else begin
              fsm_nxt = ST_IDLE;
            end
          end
        end
        default: begin
          fsm_nxt = ST_IDLE;
          cnt_nxt = '0;
        end
      endcase
    end

`ifndef LFSR_ZERO_GUARD_EN
    zlock_nxt = (lfsr_nxt == '0);
`endif
  end

  // Register update with synchronous reset to the seed and an idle, empty output.
  always_ff @(posedge clk) begin
    if (reset) begin
      fsm_q   <= ST_IDLE;
      cnt_q   <= '0;
      lfsr_q  <= SEED;
      data_q  <= '0;
      zlock_q <= 1'b0;
    end else begin
      fsm_q   <= fsm_nxt;
      cnt_q   <= cnt_nxt;
      lfsr_q  <= lfsr_nxt;
      data_q  <= data_nxt;
      zlock_q <= zlock_nxt;
    end
  end

  assign busy      = (fsm_q == ST_SHIFT) || (fsm_q == ST_VALID);
  assign out_valid = (fsm_q == ST_VALID);
  assign out_data  = data_q;
  assign state_out = lfsr_q;
  assign zero_lock = zlock_q;

endmodule

// File: tb/tb_lfsr_draw_gen.sv
// tb_lfsr_draw_gen: directed scenarios plus a randomized run of lfsr_draw_gen,
// compared every cycle against a behavioural model of draws and steps.
// Honours LFSR_ZERO_GUARD_EN the same way the design does.

module tb_lfsr_draw_gen;

  localparam int          WIDTH = 16;
  localparam int          OUT_W = 4;
  localparam logic [15:0] TAPS  = 16'hB400;
  localparam logic [15:0] SEED  = 16'h5555;

  logic             clk = 1'b0;
  logic             reset;
  logic             seed_load;
  logic [WIDTH-1:0] seed_in;
  logic             free_run;
  logic             req;
  logic             busy;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_data;
  logic [WIDTH-1:0] state_out;
  logic             zero_lock;

  int checks = 0;
  int errors = 0;

  // Behavioural model: phase 0 idle, 1 drawing, 2 word waiting for consumer
  logic [15:0] m_state;
  logic [3:0]  m_data;
  int          m_phase;
  int          m_left;
  bit          m_zl;
  bit          guard_on;

  lfsr_draw_gen #(
    .WIDTH(WIDTH), .TAPS(TAPS), .SEED(SEED), .OUT_W(OUT_W)
  ) dut (
    .clk(clk), .reset(reset), .seed_load(seed_load), .seed_in(seed_in),
    .free_run(free_run), .req(req), .busy(busy), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .state_out(state_out),
    .zero_lock(zero_lock)
  );

  always #5 clk = ~clk;

  // Feedback bit is the parity of the tapped register bits.
  function automatic bit parity_fb(input logic [15:0] s);
    int ones = 0;
    for (int i = 0; i < 16; i++) begin
      if (TAPS[i] && s[i]) ones++;
    end
    return bit'(ones % 2);
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, actual, expected, $time);
    end
  endtask

  task automatic model_edge(input bit r, input bit sl, input logic [15:0] sd,
                            input bit fr, input bit rq, input bit rdy);
    bit b;
    if (r) begin
      m_state = SEED; m_phase = 0; m_left = 0; m_data = 4'h0; m_zl = 1'b0;
      return;
    end
    if (sl) begin
      m_phase = 0;
      if (guard_on && sd == 16'h0) begin
        m_state = SEED; m_zl = 1'b1;
      end else begin
        m_state = sd;
      end
    end else if (guard_on && m_state == 16'h0) begin
      m_state = SEED; m_zl = 1'b1;
    end else if (m_phase == 0) begin
      if (rq) begin
        m_phase = 1; m_left = OUT_W;
      end else if (fr) begin
        b = parity_fb(m_state);
        m_state = (m_state << 1) | 16'(b);
      end
    end else if (m_phase == 1) begin
      b = parity_fb(m_state);
      m_state = (m_state << 1) | 16'(b);
      m_data  = (m_data << 1) | 4'(b);
      m_left  = m_left - 1;
      if (m_left == 0) m_phase = 2;
    end else if (rdy) begin
      m_phase = rq ? 1 : 0;
      m_left  = OUT_W;
    end
    if (!guard_on) m_zl = (m_state == 16'h0);
  endtask

  // Drive one cycle of inputs, advance the model on the edge, then compare away from the edge.
  task automatic applyStimulus(input bit r, input bit sl, input logic [15:0] sd,
                               input bit fr, input bit rq, input bit rdy);
    reset = r; seed_load = sl; seed_in = sd; free_run = fr; req = rq; out_ready = rdy;
    @(posedge clk);
    model_edge(r, sl, sd, fr, rq, rdy);
    #1;
    checkOutput("state_out", 32'(state_out), 32'(m_state));
    checkOutput("busy",      32'(busy),      32'(m_phase != 0));
    checkOutput("out_valid", 32'(out_valid), 32'(m_phase == 2));
    checkOutput("out_data",  32'(out_data),  32'(m_data));
    checkOutput("zero_lock", 32'(zero_lock), 32'(m_zl));
    if (out_valid) checkOutput("data_is_low_state", 32'(out_data), 32'(state_out[3:0]));
  endtask

  task automatic idle_cycles(input int n, input bit fr, input bit rq, input bit rdy);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 16'h0, fr, rq, rdy);
  endtask

  initial begin
    logic [15:0] fr_expect [4];
    int pulses;
    fr_expect[0] = 16'hAAAA; fr_expect[1] = 16'h5554;
    fr_expect[2] = 16'hAAA8; fr_expect[3] = 16'h5550;
`ifdef LFSR_ZERO_GUARD_EN
    guard_on = 1'b1;
`else
    guard_on = 1'b0;
`endif
    m_state = 16'h0; m_data = 4'h0; m_phase = 0; m_left = 0; m_zl = 1'b0;

    // Reset state
    applyStimulus(1'b1, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
    checkOutput("reset_state", 32'(state_out), 32'h5555);
    checkOutput("reset_busy",  32'(busy), 32'h0);
    checkOutput("reset_data",  32'(out_data), 32'h0);

    // Free-running sequence
    $display("[TB] free-run sequence");
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 1'b0, 16'h0, 1'b1, 1'b0, 1'b0);
      checkOutput("free_run_seq", 32'(state_out), 32'(fr_expect[i]));
    end

    // Single draw held without consumer
    $display("[TB] single draw, consumer stalled");
    applyStimulus(1'b1, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 16'h0, 1'b0, 1'b1, 1'b0);
    checkOutput("busy_at_req", 32'(busy), 32'h1);
    for (int i = 0; i < 3; i++) begin
      idle_cycles(1, 1'b1, 1'b0, 1'b0);
      checkOutput("not_valid_yet", 32'(out_valid), 32'h0);
    end
    for (int i = 0; i < 10; i++) begin
      idle_cycles(1, 1'b1, 1'b0, 1'b0);
      checkOutput("held_valid", 32'(out_valid), 32'h1);
      checkOutput("held_data",  32'(out_data), 32'h0);
      checkOutput("held_state", 32'(state_out), 32'h5550);
    end

    // Back-to-back draws: one valid pulse every five cycles
    $display("[TB] back-to-back draws");
    pulses = 0;
    for (int i = 0; i < 25; i++) begin
      idle_cycles(1, 1'b0, 1'b1, 1'b1);
      if (out_valid) pulses++;
    end
    checkOutput("pulse_count", 32'(pulses), 32'd5);

    // seed_load during a draw aborts it
    $display("[TB] seed_load during draw");
    applyStimulus(1'b1, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 16'h0, 1'b0, 1'b1, 1'b0);
    idle_cycles(1, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 16'h8001, 1'b0, 1'b0, 1'b0);
    checkOutput("seed_state", 32'(state_out), 32'h8001);
    checkOutput("seed_busy",  32'(busy), 32'h0);
    applyStimulus(1'b0, 1'b0, 16'h0, 1'b0, 1'b1, 1'b0);
    idle_cycles(4, 1'b0, 1'b0, 1'b0);
    checkOutput("seed_draw_valid", 32'(out_valid), 32'h1);
    checkOutput("seed_draw_data",  32'(out_data), 32'h8);
    checkOutput("seed_draw_state", 32'(state_out), 32'h0018);

    // Zero seed
    $display("[TB] zero seed");
    applyStimulus(1'b0, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b1);
`ifdef LFSR_ZERO_GUARD_EN
    checkOutput("zero_seed_state", 32'(state_out), 32'h5555);
`else
    checkOutput("zero_seed_state", 32'(state_out), 32'h0);
`endif
    checkOutput("zero_seed_lock", 32'(zero_lock), 32'h1);
    applyStimulus(1'b0, 1'b0, 16'h0, 1'b0, 1'b1, 1'b0);
    idle_cycles(4, 1'b0, 1'b0, 1'b0);
    checkOutput("zero_draw_data", 32'(out_data), 32'h0);
`ifdef LFSR_ZERO_GUARD_EN
    checkOutput("zero_draw_state", 32'(state_out), 32'h5550);
`else
    checkOutput("zero_draw_state", 32'(state_out), 32'h0);
`endif
    checkOutput("zero_lock_kept", 32'(zero_lock), 32'h1);

    // Randomized traffic
    $display("[TB] randomized traffic");
    applyStimulus(1'b1, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 2000; i++) begin
      bit r, sl, fr, rq, rdy;
      logic [15:0] sd;
      r   = ($urandom_range(0, 99) == 0);
      sl  = ($urandom_range(0, 39) == 0);
      sd  = ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom);
      fr  = 1'($urandom);
      rq  = ($urandom_range(0, 3) != 0);
      rdy = 1'($urandom);
      applyStimulus(r, sl, sd, fr, rq, rdy);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
